// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants and types for the small FFT/IFFT datapath blocks.
//   DEF_DATA_W  : default signed width of complex data re/im
//   DEF_TW_W    : default signed width of twiddle re/im
//   DEF_TW_FRAC : twiddle fraction bits (Q1.6, so TW_ONE = 64 means +1.0)
//   cplx_t      : packed complex sample {re, im}
//   tw_t        : packed complex twiddle {re, im}
//   TW4_0/TW4_1 : the two distinct 4-point twiddles, 1 and -j
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TW_W    = 8;
    localparam int DEF_TW_FRAC = 6;
    localparam int TW_ONE      = 1 << DEF_TW_FRAC;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] re;
        logic signed [DEF_DATA_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [DEF_TW_W-1:0] re;
        logic signed [DEF_TW_W-1:0] im;
    } tw_t;

    // W4^0 = 1 and W4^1 = -j, the only twiddles a 4-point transform needs
    localparam tw_t TW4_0 = '{re: DEF_TW_W'(TW_ONE), im: DEF_TW_W'(0)};
    localparam tw_t TW4_1 = '{re: DEF_TW_W'(0), im: DEF_TW_W'(-TW_ONE)};

endpackage

// File: rtl/pe_cmul_conj.sv
// ---------------------------------------------------------------------------
// pe_cmul_conj
// First two pipeline stages of the inverse butterfly: t = y1 * conj(w).
// Stage 1 registers the four partial products and y0; stage 2 rounds,
// rescales by the twiddle fraction bits and clamps t to DATA_W+1 bits.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   en_i              : pipeline advance (low while the output is stalled)
//   in_valid_i        : a beat is being accepted into stage 1
//   y0_*_i, y1_*_i    : butterfly sum / twiddled difference
//   tw_*_i            : forward twiddle (not conjugated)
//   s1_valid_o        : stage 1 holds a beat
//   s2_valid_o        : stage 2 holds a beat (t_*_o, y0_*_o are valid)
//   y0_*_o            : y0 delayed to line up with t
//   t_*_o             : clamped y1*conj(w), DATA_W+1 bits signed
//   sat_o             : clamping happened on the beat in stage 2
// ---------------------------------------------------------------------------
module pe_cmul_conj
    import fft_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     in_valid_i,
    input  logic signed [DATA_W-1:0] y0_re_i,
    input  logic signed [DATA_W-1:0] y0_im_i,
    input  logic signed [DATA_W-1:0] y1_re_i,
    input  logic signed [DATA_W-1:0] y1_im_i,
    input  logic signed [TW_W-1:0]   tw_re_i,
    input  logic signed [TW_W-1:0]   tw_im_i,
    output logic                     s1_valid_o,
    output logic                     s2_valid_o,
    output logic signed [DATA_W-1:0] y0_re_o,
    output logic signed [DATA_W-1:0] y0_im_o,
    output logic signed [DATA_W:0]   t_re_o,
    output logic signed [DATA_W:0]   t_im_o,
    output logic                     sat_o
);

    localparam int PW = DATA_W + TW_W;
    localparam int SW = PW + 1;
    localparam int TW = DATA_W + 1;

    localparam logic signed [SW-1:0] ROUND = SW'(2 ** (TW_FRAC - 1));
    localparam logic signed [SW-1:0] TMAX  = SW'((2 ** (TW - 1)) - 1);
    localparam logic signed [SW-1:0] TMIN  = ~TMAX;

    // Returns {clamped, value}: value limited to TW bits signed
    function automatic logic [TW:0] clampT(input logic signed [SW-1:0] x);
        if (x > TMAX) begin
            return {1'b1, TMAX[TW-1:0]};
        end else if (x < TMIN) begin
            return {1'b1, TMIN[TW-1:0]};
        end
        return {1'b0, x[TW-1:0]};
    endfunction

    logic                     v1_q, v2_q;
    logic signed [PW-1:0]     pRr_q, pIi_q, pIr_q, pRi_q;
    logic signed [PW-1:0]     pRr_d, pIi_d, pIr_d, pRi_d;
    logic signed [DATA_W-1:0] y0Re1_q, y0Im1_q, y0Re2_q, y0Im2_q;
    logic signed [SW-1:0]     sumRe, sumIm, shRe, shIm;
    logic signed [TW-1:0]     tRe_d, tIm_d, tRe_q, tIm_q;
    logic                     satRe, satIm, sat2_q;

    // Stage 1 products. Operands are sign-extended to the full product
    // width first so each multiply is a true signed PW-bit product.
    always_comb begin
        pRr_d = PW'(y1_re_i) * PW'(tw_re_i);
        pIi_d = PW'(y1_im_i) * PW'(tw_im_i);
        pIr_d = PW'(y1_im_i) * PW'(tw_re_i);
        pRi_d = PW'(y1_re_i) * PW'(tw_im_i);
    end

    // Stage 2: multiplying by conj(w) swaps the signs relative to a normal
    // complex multiply: re = rr + ii, im = ir - ri. Half an LSB is added
    // before the arithmetic shift so the rescale rounds to nearest.
    always_comb begin
        sumRe = SW'(pRr_q) + SW'(pIi_q) + ROUND;
        sumIm = SW'(pIr_q) - SW'(pRi_q) + ROUND;
        shRe  = sumRe >>> TW_FRAC;
        shIm  = sumIm >>> TW_FRAC;
        {satRe, tRe_d} = clampT(shRe);
        {satIm, tIm_d} = clampT(shIm);
    end

    // Stage valids move only when the pipe advances; data registers load
    // only when a real beat moves into them, so held stages stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            pRr_q   <= '0;
            pIi_q   <= '0;
            pIr_q   <= '0;
            pRi_q   <= '0;
            y0Re1_q <= '0;
            y0Im1_q <= '0;
            y0Re2_q <= '0;
            y0Im2_q <= '0;
            tRe_q   <= '0;
            tIm_q   <= '0;
            sat2_q  <= 1'b0;
        end else if (en_i) begin
            v1_q <= in_valid_i;
            v2_q <= v1_q;
            if (in_valid_i) begin
                pRr_q   <= pRr_d;
                pIi_q   <= pIi_d;
                pIr_q   <= pIr_d;
                pRi_q   <= pRi_d;
                y0Re1_q <= y0_re_i;
                y0Im1_q <= y0_im_i;
            end
            if (v1_q) begin
                tRe_q   <= tRe_d;
                tIm_q   <= tIm_d;
                y0Re2_q <= y0Re1_q;
                y0Im2_q <= y0Im1_q;
                sat2_q  <= satRe | satIm;
            end
        end
    end

    assign s1_valid_o = v1_q;
    assign s2_valid_o = v2_q;
    assign y0_re_o    = y0Re2_q;
    assign y0_im_o    = y0Im2_q;
    assign t_re_o     = tRe_q;
    assign t_im_o     = tIm_q;
    assign sat_o      = sat2_q;

endmodule

// File: rtl/pe_ibtf_pipe.sv
// ---------------------------------------------------------------------------
// pe_ibtf_pipe
// Inverse radix-2 butterfly, 3-stage pipeline with valid/ready handshake.
// Recovers a = (y0 + y1*conj(w)) / 2 and b = (y0 - y1*conj(w)) / 2.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   : input handshake
//   y0_*_i, y1_*_i      : forward butterfly outputs
//   tw_*_i              : the forward twiddle w
//   out_valid_o/out_ready_i : output handshake
//   a_*_o, b_*_o        : recovered inputs, saturated to DATA_W bits
//   busy_o              : some stage holds a beat
//   sat_flag_o          : sticky, some delivered beat saturated
// ---------------------------------------------------------------------------
module pe_ibtf_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [DATA_W-1:0] y0_re_i,
    input  logic signed [DATA_W-1:0] y0_im_i,
    input  logic signed [DATA_W-1:0] y1_re_i,
    input  logic signed [DATA_W-1:0] y1_im_i,
    input  logic signed [TW_W-1:0]   tw_re_i,
    input  logic signed [TW_W-1:0]   tw_im_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [DATA_W-1:0] a_re_o,
    output logic signed [DATA_W-1:0] a_im_o,
    output logic signed [DATA_W-1:0] b_re_o,
    output logic signed [DATA_W-1:0] b_im_o,
    output logic                     busy_o,
    output logic                     sat_flag_o
);

    localparam int SW3 = DATA_W + 2;
    localparam logic signed [SW3-1:0] AMAX = SW3'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SW3-1:0] AMIN = ~AMAX;

    // Halve with floor, then saturate; returns {saturated, value}
    function automatic logic [DATA_W:0] halfSat(input logic signed [SW3-1:0] x);
        logic signed [SW3-1:0] h;
        h = x >>> 1;
        if (h > AMAX) begin
            return {1'b1, AMAX[DATA_W-1:0]};
        end else if (h < AMIN) begin
            return {1'b1, AMIN[DATA_W-1:0]};
        end
        return {1'b0, h[DATA_W-1:0]};
    endfunction

    logic                     stall, advance;
    logic                     v1, v2, v3_q;
    logic signed [DATA_W-1:0] y0Re, y0Im;
    logic signed [DATA_W:0]   tRe, tIm;
    logic                     sat2;
    logic signed [SW3-1:0]    sRe, sIm, dRe, dIm;
    logic signed [DATA_W-1:0] aRe_d, aIm_d, bRe_d, bIm_d;
    logic signed [DATA_W-1:0] aRe_q, aIm_q, bRe_q, bIm_q;
    logic                     satARe, satAIm, satBRe, satBIm, sat3;
    logic                     satFlag_q;

    // The whole pipe freezes only when a result is waiting and nobody takes
    // it; that is also the only time a new beat is refused.
    assign stall      = v3_q & ~out_ready_i;
    assign advance    = ~stall;
    assign in_ready_o = advance;

    pe_cmul_conj #(
        .DATA_W  (DATA_W),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC)
    ) u_cmul (
        .clk        (clk),
        .rst        (rst),
        .en_i       (advance),
        .in_valid_i (in_valid_i),
        .y0_re_i    (y0_re_i),
        .y0_im_i    (y0_im_i),
        .y1_re_i    (y1_re_i),
        .y1_im_i    (y1_im_i),
        .tw_re_i    (tw_re_i),
        .tw_im_i    (tw_im_i),
        .s1_valid_o (v1),
        .s2_valid_o (v2),
        .y0_re_o    (y0Re),
        .y0_im_o    (y0Im),
        .t_re_o     (tRe),
        .t_im_o     (tIm),
        .sat_o      (sat2)
    );

    // Stage 3 arithmetic: sum and difference at DATA_W+2 bits cannot
    // overflow, so the only loss is the final saturation after halving.
    always_comb begin
        sRe = SW3'(y0Re) + SW3'(tRe);
        sIm = SW3'(y0Im) + SW3'(tIm);
        dRe = SW3'(y0Re) - SW3'(tRe);
        dIm = SW3'(y0Im) - SW3'(tIm);
        {satARe, aRe_d} = halfSat(sRe);
        {satAIm, aIm_d} = halfSat(sIm);
        {satBRe, bRe_d} = halfSat(dRe);
        {satBIm, bIm_d} = halfSat(dIm);
        sat3 = satARe | satAIm | satBRe | satBIm;
    end

    // Output stage and sticky flag. The flag is raised when a saturated
    // beat enters the output register, i.e. when it is about to be seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q      <= 1'b0;
            aRe_q     <= '0;
            aIm_q     <= '0;
            bRe_q     <= '0;
            bIm_q     <= '0;
            satFlag_q <= 1'b0;
        end else if (advance) begin
            v3_q <= v2;
            if (v2) begin
                aRe_q <= aRe_d;
                aIm_q <= aIm_d;
                bRe_q <= bRe_d;
                bIm_q <= bIm_d;
                if (sat2 | sat3) begin
                    satFlag_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid_o = v3_q;
    assign a_re_o      = aRe_q;
    assign a_im_o      = aIm_q;
    assign b_re_o      = bRe_q;
    assign b_im_o      = bIm_q;
    assign busy_o      = v1 | v2 | v3_q;
    assign sat_flag_o  = satFlag_q;

endmodule

// File: tb/tb_pe_ibtf_pipe.sv
// ---------------------------------------------------------------------------
// tb_pe_ibtf_pipe
// Directed bench for the inverse butterfly pipeline. Inputs are driven on
// the falling edge, outputs sampled on the falling edge (or #1 after it).
// ---------------------------------------------------------------------------
module tb_pe_ibtf_pipe;

    logic              clk;
    logic              rst;
    logic              in_valid_i;
    logic              in_ready_o;
    logic signed [7:0] y0_re_i, y0_im_i, y1_re_i, y1_im_i;
    logic signed [7:0] tw_re_i, tw_im_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic signed [7:0] a_re_o, a_im_o, b_re_o, b_im_o;
    logic              busy_o;
    logic              sat_flag_o;

    int checks   = 0;
    int failures = 0;

    pe_ibtf_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .y0_re_i     (y0_re_i),
        .y0_im_i     (y0_im_i),
        .y1_re_i     (y1_re_i),
        .y1_im_i     (y1_im_i),
        .tw_re_i     (tw_re_i),
        .tw_im_i     (tw_im_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .a_re_o      (a_re_o),
        .a_im_o      (a_im_o),
        .b_re_o      (b_re_o),
        .b_im_o      (b_im_o),
        .busy_o      (busy_o),
        .sat_flag_o  (sat_flag_o)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global guard so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one input beat (or idle when v=0)
    task automatic applyStimulus(input logic v, input int twr, input int twi,
                                 input int y0r, input int y0i,
                                 input int y1r, input int y1i);
        in_valid_i = v;
        tw_re_i    = 8'(twr);
        tw_im_i    = 8'(twi);
        y0_re_i    = 8'(y0r);
        y0_im_i    = 8'(y0i);
        y1_re_i    = 8'(y1r);
        y1_im_i    = 8'(y1i);
    endtask

    // One comparison: counts it, reports a failure with observed/expected
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Single beat through an empty pipe: checks acceptance, latency in
    // clock edges counted from the accept edge, and all four outputs.
    task automatic runBeat(input string tag, input int twr, input int twi,
                           input int y0r, input int y0i, input int y1r, input int y1i,
                           input int ear, input int eai, input int ebr, input int ebi);
        int n;
        @(negedge clk);
        out_ready_i = 1'b1;
        applyStimulus(1'b1, twr, twi, y0r, y0i, y1r, y1i);
        #1;
        checkOutput({tag, ".in_ready"}, int'(in_ready_o), 1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        while (!out_valid_o && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput({tag, ".latency"}, n, 3);
        checkOutput({tag, ".a_re"}, int'(a_re_o), ear);
        checkOutput({tag, ".a_im"}, int'(a_im_o), eai);
        checkOutput({tag, ".b_re"}, int'(b_re_o), ebr);
        checkOutput({tag, ".b_im"}, int'(b_im_o), ebi);
    endtask

    initial begin
        int sent;
        int recv;
        int lastC;
        rst         = 1'b1;
        out_ready_i = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset.out_valid", int'(out_valid_o), 0);
        checkOutput("reset.busy", int'(busy_o), 0);
        checkOutput("reset.sat_flag", int'(sat_flag_o), 0);
        checkOutput("reset.a_re", int'(a_re_o), 0);
        rst = 1'b0;
        #1;
        checkOutput("reset.in_ready", int'(in_ready_o), 1);

        // Test 1: w = 1
        runBeat("t1", 64, 0, 16, 2, 4, 6, 10, 4, 6, -2);
        // Test 2: w = -j
        runBeat("t2", 0, -64, 16, 2, 6, -4, 10, 4, 6, -2);

        // Test 4: edges that must not saturate
        runBeat("t4a", 64, 0, 127, 0, 127, 0, 127, 0, 0, 0);
        checkOutput("t4a.sat_flag", int'(sat_flag_o), 0);
        runBeat("t4b", 64, 0, -128, 0, 127, 0, -1, 0, -128, 0);
        checkOutput("t4b.sat_flag", int'(sat_flag_o), 0);
        runBeat("t4c", -64, 0, 127, 0, -128, 0, 127, 0, -1, 0);
        checkOutput("t4c.sat_flag", int'(sat_flag_o), 0);

        // Test 5: t=(179,0), a_re=306>>1 saturates to 127
        runBeat("t5", 45, 45, 127, 127, 127, 127, 127, 63, -26, 63);
        checkOutput("t5.sat_flag", int'(sat_flag_o), 1);
        runBeat("t5clean", 64, 0, 16, 2, 4, 6, 10, 4, 6, -2);
        checkOutput("t5clean.sat_flag", int'(sat_flag_o), 1);

        // Test 3: 8-beat stream, w=1, y0=(4k,-4k), y1=(2,2)
        //   a=(2k+1,-2k+1), b=(2k-1,-2k-1); out_ready low on cycles 4..8
        sent  = 0;
        recv  = 0;
        lastC = -1;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            @(negedge clk);
            out_ready_i = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
            if (sent < 8) begin
                applyStimulus(1'b1, 64, 0, 4 * sent, -4 * sent, 2, 2);
            end else begin
                applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
            end
            #1;
            if (out_valid_o && !out_ready_i) begin
                checkOutput("t3.stall_in_ready", int'(in_ready_o), 0);
                checkOutput("t3.held_a_re", int'(a_re_o), 2 * recv + 1);
            end
            if (out_valid_o && out_ready_i) begin
                checkOutput("t3.a_re", int'(a_re_o), 2 * recv + 1);
                checkOutput("t3.a_im", int'(a_im_o), -2 * recv + 1);
                checkOutput("t3.b_re", int'(b_re_o), 2 * recv - 1);
                checkOutput("t3.b_im", int'(b_im_o), -2 * recv - 1);
                recv++;
                lastC = c;
            end
            if (in_valid_i && in_ready_o) begin
                sent++;
            end
            @(posedge clk);
        end
        checkOutput("t3.received", recv, 8);
        checkOutput("t3.last_cycle", lastC, 15);
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3.no_extra", int'(out_valid_o), 0);

        // Test 6: async reset with three beats in flight
        out_ready_i = 1'b1;
        applyStimulus(1'b1, 64, 0, 16, 2, 4, 6);
        @(negedge clk);
        applyStimulus(1'b1, 64, 0, 20, 0, 2, 0);
        @(negedge clk);
        applyStimulus(1'b1, 64, 0, 24, 0, 2, 0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6.pre_busy", int'(busy_o), 1);
        checkOutput("t6.pre_out_valid", int'(out_valid_o), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6.out_valid", int'(out_valid_o), 0);
        checkOutput("t6.busy", int'(busy_o), 0);
        checkOutput("t6.sat_flag", int'(sat_flag_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t6.in_ready", int'(in_ready_o), 1);
        runBeat("t6post", 64, 0, 16, 2, 4, 6, 10, 4, 6, -2);
        checkOutput("t6post.sat_flag", int'(sat_flag_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
